// File: rtl/sbox_layer_sched_masked_if.sv
// Bus bundle between the S-box layer scheduler and its neighbours: the round datapath,
// the PRNG and the shared masked S-box instance.
interface sbox_layer_sched_masked_if #(
    parameter int FRESH_W = 13
);
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_s0;
    logic [63:0]        in_s1;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [FRESH_W-1:0] rnd_data;
    logic [3:0]         sb_in_s0;
    logic [3:0]         sb_in_s1;
    logic [FRESH_W-1:0] sb_fresh;
    logic               sb_rst;
    logic               sb_synch;
    logic [3:0]         sb_out_s0;
    logic [3:0]         sb_out_s1;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_s0;
    logic [63:0]        out_s1;
    logic               err;

    // slave: the scheduler itself; master: everything around it
    modport slave (
        input  in_valid, in_s0, in_s1, rnd_valid, rnd_data, sb_synch, sb_out_s0, sb_out_s1,
               out_ready,
        output in_ready, rnd_ready, sb_in_s0, sb_in_s1, sb_fresh, sb_rst, out_valid, out_s0,
               out_s1, err
    );

    modport master (
        output in_valid, in_s0, in_s1, rnd_valid, rnd_data, sb_synch, sb_out_s0, sb_out_s1,
               out_ready,
        input  in_ready, rnd_ready, sb_in_s0, sb_in_s1, sb_fresh, sb_rst, out_valid, out_s0,
               out_s1, err
    );
endinterface

// File: rtl/sbox_layer_sched_masked.sv
// Runs a 2-share 64-bit state nibble by nibble through one shared masked S-box, fetching
// fresh randomness per nibble and restarting the S-box gating controller between nibbles.
//
//   state | meaning
//   IDLE  | waiting for a state to process (in_ready high)
//   FETCH | waiting for a fresh randomness word for nibble idx
//   RUN   | S-box running on nibble idx, waiting for Synch
//   CAPT  | writing the S-box result into nibble idx of the output shares
//   DONE  | result presented until the consumer takes it
module sbox_layer_sched_masked #(
    parameter int NIBBLES = 16,
    parameter int LATENCY = 11,
    parameter int FRESH_W = 13
) (
    input logic                      clk,
    input logic                      rst,
    sbox_layer_sched_masked_if.slave bus
);
    localparam int IDX_W = $clog2(NIBBLES);
    localparam int CNT_W = $clog2(LATENCY + 3);

    typedef enum logic [2:0] {IDLE, FETCH, RUN, CAPT, DONE} state_e;

    state_e             state_q, state_d;
    logic [63:0]        sh_s0_q, sh_s0_d, sh_s1_q, sh_s1_d;
    logic [63:0]        out_s0_q, out_s0_d, out_s1_q, out_s1_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [3:0]         sb_in_s0_q, sb_in_s0_d, sb_in_s1_q, sb_in_s1_d;
    logic [FRESH_W-1:0] sb_fresh_q, sb_fresh_d;
    logic               sb_rst_q, sb_rst_d;
    logic               in_ready_q, in_ready_d;
    logic               rnd_ready_q, rnd_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    always_comb begin
        state_d    = state_q;
        sh_s0_d    = sh_s0_q;
        sh_s1_d    = sh_s1_q;
        out_s0_d   = out_s0_q;
        out_s1_d   = out_s1_q;
        idx_d      = idx_q;
        run_cnt_d  = run_cnt_q;
        sb_in_s0_d = sb_in_s0_q;
        sb_in_s1_d = sb_in_s1_q;
        sb_fresh_d = sb_fresh_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sh_s0_d  = bus.in_s0;
                    sh_s1_d  = bus.in_s1;
                    out_s0_d = '0;
                    out_s1_d = '0;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // S-box operands only ever change here, so they are stable for the whole run
                if (bus.rnd_valid && rnd_ready_q) begin
                    sb_fresh_d = bus.rnd_data;
                    sb_in_s0_d = sh_s0_q[{idx_q, 2'b00} +: 4];
                    sb_in_s1_d = sh_s1_q[{idx_q, 2'b00} +: 4];
                    run_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                if (bus.sb_synch) begin
                    state_d = CAPT;
                end else if (run_cnt_q == CNT_W'(LATENCY + 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPT: begin
                out_s0_d[{idx_q, 2'b00} +: 4] = bus.sb_out_s0;
                out_s1_d[{idx_q, 2'b00} +: 4] = bus.sb_out_s1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // handshake and S-box control outputs are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        rnd_ready_d = (state_d == FETCH);
        sb_rst_d    = (state_d != RUN);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_s0_q     <= '0;
            sh_s1_q     <= '0;
            out_s0_q    <= '0;
            out_s1_q    <= '0;
            idx_q       <= '0;
            run_cnt_q   <= '0;
            sb_in_s0_q  <= '0;
            sb_in_s1_q  <= '0;
            sb_fresh_q  <= '0;
            sb_rst_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_s0_q     <= sh_s0_d;
            sh_s1_q     <= sh_s1_d;
            out_s0_q    <= out_s0_d;
            out_s1_q    <= out_s1_d;
            idx_q       <= idx_d;
            run_cnt_q   <= run_cnt_d;
            sb_in_s0_q  <= sb_in_s0_d;
            sb_in_s1_q  <= sb_in_s1_d;
            sb_fresh_q  <= sb_fresh_d;
            sb_rst_q    <= sb_rst_d;
            in_ready_q  <= in_ready_d;
            rnd_ready_q <= rnd_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rnd_ready = rnd_ready_q;
    assign bus.sb_in_s0  = sb_in_s0_q;
    assign bus.sb_in_s1  = sb_in_s1_q;
    assign bus.sb_fresh  = sb_fresh_q;
    assign bus.sb_rst    = sb_rst_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s0    = out_s0_q;
    assign bus.out_s1    = out_s1_q;
    assign bus.err       = err_q;
endmodule
